// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encodings match the EXE-stage decode of MULT/MULTU/DIV/DIVU.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } md_state_e;

  localparam logic [63:0] MD_DZ_QUO = '1;

  function automatic logic md_is_signed(input md_op_e o);
    return ~o[0];
  endfunction

  function automatic logic md_is_div(input md_op_e o);
    return o[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// acc is the upper product / remainder, lo the multiplier / quotient.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] trial;
  logic           ge;

  always_comb begin
    sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    shl   = {acc, lo[WIDTH-1]};
    trial = shl - {1'b0, opnd};
    ge    = shl >= {1'b0, opnd};
    if (is_div) begin
      acc_n = ge ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
      lo_n  = {lo[WIDTH-2:0], ge};
    end else begin
      // carry from the add shifts into the top of the accumulator
      acc_n = sum[WIDTH:1];
      lo_n  = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Fixed latency of WIDTH+2 edges from acceptance to result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             rd_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e state;
  md_state_e state_n;
  md_op_e    op_q;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   lo_w;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]   lo_n;
  logic [CW-1:0]      count;
  logic               sign_q;
  logic               sign_r;
  logic               accept;
  logic               is_div;
  logic               is_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;

  assign is_div = md_is_div(op_q);
  assign is_sgn = md_is_signed(op_q);
  assign busy   = state != IDLE;
  assign stall  = busy & (start | rd_req | wr_hi | wr_lo);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc    (acc),
    .lo     (lo_w),
    .opnd   (opnd),
    .acc_n  (acc_n),
    .lo_n   (lo_n)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          state_n = PREP;
          accept  = 1'b1;
        end
      end
      PREP: state_n = ITER;
      ITER: if (count == LAST) state_n = FIX;
      FIX:  state_n = IDLE;
    endcase
    if (flush && state != IDLE) state_n = IDLE;
  end

  always_comb begin
    a_mag  = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag  = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    prod   = {acc, lo_w};
    prod_f = sign_q ? -prod : prod;
    quo_f  = sign_q ? -lo_w : lo_w;
    rem_f  = sign_r ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MD_MULT;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      lo_w   <= '0;
      opnd   <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q <= md_op_e'(op);
            a_q  <= op_a;
            b_q  <= op_b;
          end else if (!start) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        PREP: begin
          acc    <= '0;
          count  <= '0;
          sign_q <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_sgn & a_q[WIDTH-1];
          lo_w   <= is_div ? a_mag : b_mag;
          opnd   <= is_div ? b_mag : a_mag;
        end
        ITER: begin
          acc   <= acc_n;
          lo_w  <= lo_n;
          count <= count + CW'(1);
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_f;
            end else if (b_q == '0) begin
              hi <= a_q;
              lo <= WIDTH'(MD_DZ_QUO);
            end else begin
              hi <= rem_f;
              lo <= quo_f;
            end
          end
        end
      endcase
    end
  end

endmodule
